// File: rtl/sipo_frame_rx.sv
// Serial-in/parallel-out frame receiver: start bit, WIDTH data bits MSB-first, stop bit,
// with a one-word valid/ready output register and framing-error / overrun pulses.
module sipo_frame_rx #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_STOP  = 2'd2,
    ST_BREAK = 2'd3
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] data_reg;
  logic             valid_reg;
  logic             frame_err_reg;
  logic             overrun_reg;
  logic             word_done;
  logic             stop_bad;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (!serial_in) state_next = ST_DATA;
      ST_DATA:  if (cnt_reg == CNT_W'(WIDTH - 1)) state_next = ST_STOP;
      ST_STOP:  state_next = serial_in ? ST_IDLE : ST_BREAK;
      ST_BREAK: if (serial_in) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Output / decode logic
  always_comb begin
    busy      = (state_reg != ST_IDLE);
    word_done = (state_reg == ST_STOP) && serial_in;
    stop_bad  = (state_reg == ST_STOP) && !serial_in;
  end

  // Bit counter and shift register; the counter is re-armed every pass through IDLE
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_reg   <= '0;
      shift_reg <= '0;
    end else if (state_reg == ST_IDLE) begin
      cnt_reg <= '0;
    end else if (state_reg == ST_DATA) begin
      cnt_reg   <= cnt_reg + 1'b1;
      shift_reg <= {shift_reg[WIDTH-2:0], serial_in};
    end
  end

  // Output register: a completing word wins over a plain transfer, and is dropped only
  // when the held word is not being consumed on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      frame_err_reg <= stop_bad;
      overrun_reg   <= 1'b0;
      if (word_done) begin
        if (!valid_reg || ready) begin
          data_reg  <= shift_reg;
          valid_reg <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end else if (valid_reg && ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign data_out  = data_reg;
  assign valid     = valid_reg;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Self-checking bench for sipo_frame_rx: directed scenarios plus randomized frames,
// compared every cycle against a frame-level reference model.
module tb_sipo_frame_rx;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             serial_in = 1'b1;
  logic             ready = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             valid;
  logic             busy;
  logic             frame_err;
  logic             overrun;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: position in the frame (-1 idle, -2 waiting out a break,
  // 0..WIDTH-1 data bits received, WIDTH = expecting stop bit)
  int               m_pos = -1;
  logic [WIDTH-1:0] m_word = '0;
  logic [WIDTH-1:0] m_dout = '0;
  logic             m_valid = 1'b0;
  logic             m_ferr = 1'b0;
  logic             m_ovr = 1'b0;

  sipo_frame_rx #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .serial_in (serial_in),
    .data_out  (data_out),
    .valid     (valid),
    .ready     (ready),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic s, input logic r, input logic rn);
    logic comp;
    logic ferr;
    comp = 1'b0;
    ferr = 1'b0;
    if (!rn) begin
      m_pos   = -1;
      m_word  = '0;
      m_dout  = '0;
      m_valid = 1'b0;
      m_ferr  = 1'b0;
      m_ovr   = 1'b0;
    end else begin
      if (m_pos == -1) begin
        if (!s) m_pos = 0;
      end else if (m_pos == -2) begin
        if (s) m_pos = -1;
      end else if (m_pos < WIDTH) begin
        m_word = m_word * 2 + WIDTH'(s);
        m_pos++;
      end else if (s) begin
        comp  = 1'b1;
        m_pos = -1;
      end else begin
        ferr  = 1'b1;
        m_pos = -2;
      end
      m_ovr = 1'b0;
      if (comp) begin
        if (!m_valid || r) begin
          m_dout  = m_word;
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && r) begin
        m_valid = 1'b0;
      end
      m_ferr = ferr;
    end
  endtask

  // One clock: drive inputs, let the edge happen, then compare on the falling edge
  task automatic step(input logic s, input logic r, input logic rn);
    serial_in = s;
    ready     = r;
    rst       = rn;
    @(posedge clk);
    model_edge(s, r, rn);
    @(negedge clk);
    check("valid", 32'(valid), 32'(m_valid));
    check("data_out", data_out, m_dout);
    check("busy", 32'(busy), 32'(m_pos != -1));
    check("frame_err", 32'(frame_err), 32'(m_ferr));
    check("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] w, input logic stop,
                            input logic r_data, input logic r_stop);
    $display("frame %h stop=%b ready=%b/%b", w, stop, r_data, r_stop);
    step(1'b0, r_data, 1'b1);
    for (int i = WIDTH - 1; i >= 0; i--) step(w[i], r_data, 1'b1);
    step(stop, r_stop, 1'b1);
  endtask

  initial begin
    logic [WIDTH-1:0] w;
    logic             stop;

    // Reset and long idle
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b1);

    // Single frame, consumer always ready
    send_frame(32'hB77BEFDF, 1'b1, 1'b1, 1'b1);
    check("single_valid", 32'(valid), 32'd1);
    check("single_data", data_out, 32'hB77BEFDF);
    step(1'b1, 1'b1, 1'b1);
    check("single_clear", 32'(valid), 32'd0);
    step(1'b1, 1'b1, 1'b1);

    // Back-to-back frames under backpressure: second word is dropped
    send_frame(32'hB77BEFDF, 1'b1, 1'b0, 1'b0);
    send_frame(32'h00000001, 1'b1, 1'b0, 1'b0);
    check("ovr_pulse", 32'(overrun), 32'd1);
    check("ovr_hold", data_out, 32'hB77BEFDF);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check("ovr_drain", 32'(valid), 32'd0);
    step(1'b1, 1'b0, 1'b1);

    // Transfer on the same edge the next word completes
    send_frame(32'hAAAA5555, 1'b1, 1'b0, 1'b0);
    send_frame(32'h0F0F1234, 1'b1, 1'b0, 1'b1);
    check("coinc_valid", 32'(valid), 32'd1);
    check("coinc_data", data_out, 32'h0F0F1234);
    check("coinc_no_ovr", 32'(overrun), 32'd0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);

    // Framing error followed by a held-low line, then a good frame
    send_frame(32'hDEADBEEF, 1'b0, 1'b1, 1'b1);
    check("ferr_pulse", 32'(frame_err), 32'd1);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b1);
    check("ferr_busy", 32'(busy), 32'd1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    send_frame(32'h12345678, 1'b1, 1'b1, 1'b1);
    check("after_ferr_data", data_out, 32'h12345678);
    step(1'b1, 1'b1, 1'b1);

    // Reset after 10 data bits aborts the frame
    w = 32'hFFC0FFEE;
    step(1'b0, 1'b1, 1'b1);
    for (int i = WIDTH - 1; i >= WIDTH - 10; i--) step(w[i], 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check("midrst_busy", 32'(busy), 32'd0);
    send_frame(32'hA5A5A5A5, 1'b1, 1'b0, 1'b0);
    check("midrst_data", data_out, 32'hA5A5A5A5);
    step(1'b1, 1'b1, 1'b1);

    // Randomized frames, stop errors, gaps and ready
    for (int f = 0; f < 60; f++) begin
      w    = $urandom;
      stop = ($urandom_range(0, 7) != 0);
      $display("rand frame %0d: %h stop=%b", f, w, stop);
      step(1'b0, 1'($urandom_range(0, 1)), 1'b1);
      for (int i = WIDTH - 1; i >= 0; i--) step(w[i], 1'($urandom_range(0, 1)), 1'b1);
      step(stop, 1'($urandom_range(0, 1)), 1'b1);
      if (!stop) begin
        for (int i = 0; i < int'($urandom_range(0, 3)); i++)
          step(1'b0, 1'($urandom_range(0, 1)), 1'b1);
        step(1'b1, 1'($urandom_range(0, 1)), 1'b1);
      end
      for (int i = 0; i < int'($urandom_range(0, 2)); i++)
        step(1'b1, 1'($urandom_range(0, 1)), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
